// File: rtl/smol_load_store.sv
// smol_load_store
//   Core-side initiator for the smolCore word-addressed data memory. Takes
//   byte/half/word load/store requests over a valid/ready handshake, checks
//   alignment and range, then drives a single-port memory. Sub-word stores do a
//   read-modify-write. Sub-word loads are extracted and zero- or sign-extended.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   req_*            request channel (req_ready is high only in IDLE)
//   resp_*           one-cycle completion pulse with load data and error flags
//   mem_*            memory port; read data returns on mem_rdata one cycle later,
//                    writes commit at the edge where mem_write is high
module smol_load_store #(
    parameter int unsigned MEM_WORDS = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDW,
        S_WR,
        S_RESP,
        S_ERR
    } state_t;

    state_t      state;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        uns_q;
    logic [15:0] wdata_q;
    logic        mem_read_q;
    logic        mem_write_q;

    // Request checks, evaluated on the live request fields at accept
    logic [31:0] offset;
    logic        misaligned;
    logic        fault;

    always_comb begin
        offset     = req_addr - BASE_ADDR;
        misaligned = (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        fault      = (offset >= MEM_BYTES);
    end

    // Load lane extraction and sub-word store merge, both from mem_rdata in RDW
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [31:0] merged;

    always_comb begin
        shifted = mem_rdata >> {lane_q, 3'b000};
        case (size_q)
            2'b00:   load_val = uns_q ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = uns_q ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase

        merged = mem_rdata;
        if (size_q == 2'b00)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            resp_fault      <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            wr_q            <= 1'b0;
            size_q          <= '0;
            lane_q          <= '0;
            uns_q           <= 1'b0;
            wdata_q         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_q       <= req_write;
                        size_q     <= req_size;
                        lane_q     <= req_addr[1:0];
                        uns_q      <= req_unsigned;
                        wdata_q    <= req_wdata[15:0];
                        mem_addr   <= {req_addr[31:2], 2'b00};
                        resp_rdata <= '0;
                        req_ready  <= 1'b0;
                        if (misaligned) begin
                            resp_valid      <= 1'b1;
                            resp_misaligned <= 1'b1;
                            state           <= S_ERR;
                        end else if (fault) begin
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            state      <= S_ERR;
                        end else if (req_write && (req_size == 2'b10)) begin
                            mem_write_q <= 1'b1;
                            mem_wdata   <= req_wdata;
                            state       <= S_WR;
                        end else begin
                            mem_read_q <= 1'b1;
                            state      <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    mem_read_q <= 1'b0;
                    state      <= S_RDW;
                end
                S_RDW: begin
                    if (wr_q) begin
                        mem_wdata   <= merged;
                        mem_write_q <= 1'b1;
                        state       <= S_WR;
                    end else begin
                        resp_rdata <= load_val;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_WR: begin
                    mem_write_q <= 1'b0;
                    resp_valid  <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP, S_ERR: begin
                    resp_valid      <= 1'b0;
                    resp_misaligned <= 1'b0;
                    resp_fault      <= 1'b0;
                    resp_rdata      <= '0;
                    req_ready       <= 1'b1;
                    state           <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Strobes are masked by rst so an access pending in RD/WR never reaches
    // the memory on a reset edge.
    assign mem_read  = mem_read_q & ~rst;
    assign mem_write = mem_write_q & ~rst;

endmodule
